// File: rtl/exe_mult_div_if.sv
// Multiply/divide request and result bundle between decode and the MD unit.
// master: decode side (drives requests). slave: MD unit (drives busy/results).
interface exe_mult_div_if #(
    parameter int WIDTH = 32
);
    logic               mult_en;
    logic               div_en;
    logic               is_signed;
    logic [WIDTH-1:0]   src1;
    logic [WIDTH-1:0]   src2;
    logic               cancel;
    logic               busy;
    logic               md_complete;
    logic [2*WIDTH-1:0] md_result;

    modport master (
        output mult_en, div_en, is_signed, src1, src2, cancel,
        input  busy, md_complete, md_result
    );

    modport slave (
        input  mult_en, div_en, is_signed, src1, src2, cancel,
        output busy, md_complete, md_result
    );
endinterface

// File: rtl/exe_mult_div.sv
// Iterative radix-2 multiply/divide unit; result {HI,LO} = md_result.
// Ports: clk, resetn (async low), md (slave: starts/operands/cancel in,
// busy/md_complete/md_result out). MD_FAST_MULT_EN: single-cycle multiply.
module exe_mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           resetn,
    exe_mult_div_if.slave  md
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               div_q, div_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic               start;
    logic               sign1, sign2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     shl;
    logic [WIDTH+1:0]   sub;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [2*WIDTH-1:0] p_fix, fin;
    logic               complete;

    assign start = (md.mult_en | md.div_en) & ~md.cancel;
    assign sign1 = md.is_signed & md.src1[WIDTH-1];
    assign sign2 = md.is_signed & md.src2[WIDTH-1];
    assign mag1  = sign1 ? -md.src1 : md.src1;
    assign mag2  = sign2 ? -md.src2 : md.src2;

    // Multiply: p = {acc, multiplier}; add into the top half, shift right.
    assign add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    // Divide: p = {rem, dividend/quotient}; an extra bit detects borrow.
    assign shl = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign sub = {1'b0, shl} - {2'b00, b_q};

    assign p_fix = negq_q ? -p_q : p_q;
    assign q_fix = negq_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign r_fix = negr_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    assign fin   = div_q ? {r_fix, q_fix} : p_fix;

    // Result shows through combinationally so a cancel in DONE leaves it intact.
    assign complete       = (state_q == S_DONE) & ~md.cancel;
    assign md.busy        = (state_q != S_IDLE);
    assign md.md_complete = complete;
    assign md.md_result   = complete ? fin : res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div_d   = div_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = mag1;
                    b_d    = mag2;
                    negq_d = sign1 ^ sign2;
                    negr_d = sign1;
                    cnt_d  = '0;
                    div_d  = ~md.mult_en;
                    if (md.mult_en) begin
`ifdef MD_FAST_MULT_EN
                        p_d     = {{WIDTH{1'b0}}, mag1}
                                * {{WIDTH{1'b0}}, mag2};
                        state_d = S_DONE;
`else
                        p_d     = {{WIDTH{1'b0}}, mag2};
                        state_d = S_MUL;
`endif
                    end else begin
                        p_d     = {{WIDTH{1'b0}}, mag1};
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                p_d   = {add_s, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DIV: begin
                if (!sub[WIDTH+1]) begin
                    p_d = {sub[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = {shl[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (complete) res_d = fin;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && md.cancel) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div_q   <= div_d;
            res_q   <= res_d;
        end
    end
endmodule
